serial_word_comparator: RTL and testbench
=========================================

Name: serial_word_comparator

Overview:
- Sequential successor of the single-bit equality comparator. Compares two WIDTH-bit words one bit per clock, MSB first.
- Produces registered EQ/GT/LT flags with a START/BUSY/DONE handshake.
- Used where the datapath serialises comparisons to save area. Supports unsigned or two's-complement operands.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when BUSY=0.
- A  input  WIDTH  operand A; captured on accepted START.
- B  input  WIDTH  operand B; captured on accepted START.
- BUSY  output  1  comparison in progress.
- DONE  output  1  one-cycle pulse; result valid.
- EQ  output  1  A == B.
- GT  output  1  A > B.
- LT  output  1  A < B.

Interface rule: one clock, CLK. RST is synchronous and active-high.

Behaviour:
- Reset (RST=1 at a rising edge): state IDLE; BUSY, DONE, EQ, GT and LT all 0; internal registers cleared. RST has priority over everything, including mid-comparison; any operation in flight is abandoned and no DONE is issued.
- States: IDLE, COMPARE, FINISH.
- IDLE:
  - START=1 → capture A and B into shift registers.
  - Bit counter := WIDTH-1; decided flag := 0; EQ/GT/LT := 0.
  - Go to COMPARE.
- COMPARE (BUSY=1):
  - Each cycle examines bit pair [cnt] and decrements cnt.
  - While undecided, the first differing pair sets the decision.
  - Unsigned, or signed at a bit other than WIDTH-1: A bit = 1 → GT.
  - Signed at bit WIDTH-1: A bit = 1 → LT (A is negative).
  - After the decision, later bits do not change GT/LT.
  - cnt == 0 → go to FINISH.
  - Occupancy: exactly WIDTH cycles.
- FINISH (BUSY=0):
  - DONE=1 for exactly one cycle.
  - EQ=1 if no pair differed; otherwise exactly one of GT/LT is 1.
  - Go to IDLE, or directly to COMPARE if START=1 in this cycle (back-to-back; operands captured as in IDLE).
- Latency: START sampled at edge k → DONE high during the cycle after edge k+WIDTH+1 (WIDTH+1 cycles after the START edge). Fixed; independent of operand values.
- Results EQ/GT/LT hold from the DONE cycle until the next accepted START, which clears them to 0.
- Exactly one of EQ/GT/LT is 1 whenever a result is valid; none is 1 otherwise.
- START while BUSY=1 is ignored; the operation in flight is unaffected.
- A/B changes after capture have no effect.

Optional Feature:
- Macro: HAMMING_DIST_EN.
- Defined: extra output DIFF_CNT, width $clog2(WIDTH+1).
  - Cleared on reset and on accepted START.
  - Increments once per differing bit pair in COMPARE; counts all WIDTH bits, never stops early.
  - Valid and held from DONE until the next accepted START.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan (WIDTH=8 unless stated):
- A=0x5A, B=0x5A, START one cycle → BUSY high 8 cycles; DONE pulse 9 cycles after START edge; EQ=1, GT=0, LT=0; DIFF_CNT=0.
- SIGNED=0, A=0x80, B=0x7F → GT=1, LT=0, EQ=0; DIFF_CNT=8. Same operands with SIGNED=1 → LT=1, GT=0.
- A=0x03, B=0x02, then A=0xFF, B=0xFE → GT=1 both times (decision at LSB); DIFF_CNT=1.
- START pulsed again at cycle 3 of a comparison with different A/B → ignored; result matches the first operands; single DONE pulse.
- RST asserted at cycle 4 of COMPARE → next cycle BUSY=0, all flags 0; no DONE issued; new START afterwards completes normally.
- START held high through the FINISH cycle → DONE pulses once, new comparison starts immediately with no IDLE cycle; EQ/GT/LT cleared; second DONE exactly 9 cycles after the first.

Source files
------------

// File: rtl/serial_word_comparator.sv
// Bit-serial magnitude comparator: compares two WIDTH-bit words MSB first and reports EQ/GT/LT.
// Optional macro HAMMING_DIST_EN adds DIFF_CNT, the number of differing bit pairs.
module serial_word_comparator #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic             GT,
    output logic             LT
`ifdef HAMMING_DIST_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] DIFF_CNT
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] TOP_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             a_greater;
    logic             done_q;
    logic             bit_differs;
    logic             sign_bit;

    assign bit_differs = a_q[cnt] ^ b_q[cnt];
    assign sign_bit    = (SIGNED != 0) && (cnt == TOP_BIT);
    assign BUSY        = (state == COMPARE);
    assign DONE        = done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (cnt == '0) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = COMPARE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are published one edge after FINISH, alongside DONE; in back-to-back
    // operation they are cleared once that DONE cycle has passed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            decided   <= 1'b0;
            a_greater <= 1'b0;
            done_q    <= 1'b0;
            EQ        <= 1'b0;
            GT        <= 1'b0;
            LT        <= 1'b0;
        end else begin
            done_q <= (state == FINISH);
            if (accept) begin
                a_q       <= A;
                b_q       <= B;
                cnt       <= TOP_BIT;
                decided   <= 1'b0;
                a_greater <= 1'b0;
            end else if (state == COMPARE) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
                if (bit_differs && !decided) begin
                    decided   <= 1'b1;
                    a_greater <= a_q[cnt] ^ sign_bit;
                end
            end
            if (state == FINISH) begin
                EQ <= !decided;
                GT <= decided && a_greater;
                LT <= decided && !a_greater;
            end else if (accept || (done_q && state == COMPARE)) begin
                EQ <= 1'b0;
                GT <= 1'b0;
                LT <= 1'b0;
            end
        end
    end

`ifdef HAMMING_DIST_EN
    localparam int DW = $clog2(WIDTH + 1);

    logic [DW-1:0] diff_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            diff_q   <= '0;
            DIFF_CNT <= '0;
        end else begin
            if (accept) begin
                diff_q <= '0;
            end else if (state == COMPARE && bit_differs) begin
                diff_q <= diff_q + 1'b1;
            end
            if (state == FINISH) begin
                DIFF_CNT <= diff_q;
            end else if (accept || (done_q && state == COMPARE)) begin
                DIFF_CNT <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_comparator.sv
// Randomised self-checking bench: unsigned and signed instances share stimulus and are
// checked cycle by cycle against arithmetic comparisons of the captured operands.
module tb_serial_word_comparator;

    localparam int W = 8;
    localparam int DW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy_u, done_u, eq_u, gt_u, lt_u;
    logic         busy_s, done_s, eq_s, gt_s, lt_s;
`ifdef HAMMING_DIST_EN
    logic [DW-1:0] diff_u, diff_s;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_word_comparator #(.WIDTH(W), .SIGNED(0)) dut_u (
        .CLK(clk), .RST(rst), .START(start), .A(a), .B(b),
        .BUSY(busy_u), .DONE(done_u), .EQ(eq_u), .GT(gt_u), .LT(lt_u)
`ifdef HAMMING_DIST_EN
        , .DIFF_CNT(diff_u)
`endif
    );

    serial_word_comparator #(.WIDTH(W), .SIGNED(1)) dut_s (
        .CLK(clk), .RST(rst), .START(start), .A(a), .B(b),
        .BUSY(busy_s), .DONE(done_s), .EQ(eq_s), .GT(gt_s), .LT(lt_s)
`ifdef HAMMING_DIST_EN
        , .DIFF_CNT(diff_s)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference result as {EQ,GT,LT} straight from arithmetic comparison.
    function automatic logic [2:0] expFlags(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        if (x == y) return 3'b100;
        if (sgn) return ($signed(x) > $signed(y)) ? 3'b010 : 3'b001;
        return (x > y) ? 3'b010 : 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCycle(input string tag, input int c, input logic exp_busy, input logic exp_done,
                              input logic [2:0] fu, input logic [2:0] fs, input int dcnt);
        checkOutput($sformatf("%s busy_u c%0d", tag, c), 32'(busy_u), 32'(exp_busy));
        checkOutput($sformatf("%s busy_s c%0d", tag, c), 32'(busy_s), 32'(exp_busy));
        checkOutput($sformatf("%s done_u c%0d", tag, c), 32'(done_u), 32'(exp_done));
        checkOutput($sformatf("%s done_s c%0d", tag, c), 32'(done_s), 32'(exp_done));
        checkOutput($sformatf("%s flags_u c%0d", tag, c), 32'({eq_u, gt_u, lt_u}), 32'(fu));
        checkOutput($sformatf("%s flags_s c%0d", tag, c), 32'({eq_s, gt_s, lt_s}), 32'(fs));
`ifdef HAMMING_DIST_EN
        checkOutput($sformatf("%s diff_u c%0d", tag, c), 32'(diff_u), 32'(dcnt));
        checkOutput($sformatf("%s diff_s c%0d", tag, c), 32'(diff_s), 32'(dcnt));
`endif
    endtask

    // Follows an accepted operation from the cycle after its START edge to its DONE pulse;
    // an optional stray START is raised while BUSY and must be ignored.
    task automatic watchResult(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input int ignore_at);
        for (int c = 1; c <= W + 1; c++) begin
            if (c == ignore_at) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            start = 1'b0;
            if (c == W + 1)
                checkCycle(tag, c, 1'b0, 1'b1, expFlags(x, y, 1'b0), expFlags(x, y, 1'b1), $countones(x ^ y));
            else
                checkCycle(tag, c, c < W, 1'b0, 3'b000, 3'b000, 0);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input int ignore_at);
        start = 1'b1;
        a = x;
        b = y;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        checkCycle(tag, 0, 1'b1, 1'b0, 3'b000, 3'b000, 0);
        watchResult(tag, x, y, ignore_at);
        tick();
        checkCycle({tag, " hold"}, W + 2, 1'b0, 1'b0, expFlags(x, y, 1'b0), expFlags(x, y, 1'b1), $countones(x ^ y));
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        rst = 1'b0;
        checkCycle("reset", 0, 1'b0, 1'b0, 3'b000, 3'b000, 0);

        applyStimulus("equal", 8'h5A, 8'h5A, 0);
        applyStimulus("msb", 8'h80, 8'h7F, 0);
        applyStimulus("lsb1", 8'h03, 8'h02, 0);
        applyStimulus("lsb2", 8'hFF, 8'hFE, 0);
        applyStimulus("ignore", 8'h12, 8'h34, 3);

        // Reset during the fourth COMPARE cycle abandons the operation silently.
        start = 1'b1;
        a = 8'hC3;
        b = 8'h3C;
        tick();
        start = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkCycle("midreset", 0, 1'b0, 1'b0, 3'b000, 3'b000, 0);
        for (int c = 1; c <= W + 2; c++) begin
            tick();
            checkCycle("midreset", c, 1'b0, 1'b0, 3'b000, 3'b000, 0);
        end
        applyStimulus("afterreset", 8'h7E, 8'h81, 0);

        // START held high through FINISH chains a second operation with no IDLE cycle.
        x = 8'h80;
        y = 8'h01;
        start = 1'b1;
        a = 8'h40;
        b = 8'hC0;
        tick();
        a = x;
        b = y;
        checkCycle("b2b", 0, 1'b1, 1'b0, 3'b000, 3'b000, 0);
        for (int c = 1; c <= W; c++) begin
            tick();
            checkCycle("b2b", c, c < W, 1'b0, 3'b000, 3'b000, 0);
        end
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        checkCycle("b2b first", W + 1, 1'b1, 1'b1, expFlags(8'h40, 8'hC0, 1'b0), expFlags(8'h40, 8'hC0, 1'b1),
                   $countones(8'h40 ^ 8'hC0));
        watchResult("b2b second", x, y, 0);
        tick();
        checkCycle("b2b hold", 0, 1'b0, 1'b0, expFlags(x, y, 1'b0), expFlags(x, y, 1'b1), $countones(x ^ y));

        for (int t = 0; t < 24; t++) begin
            x = W'($urandom);
            y = (t % 4 == 0) ? x : W'($urandom);
            applyStimulus($sformatf("rand%0d", t), x, y, (t % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
